ntt_conf_sequencer: RTL and testbench

- Drives the 4-bit `conf` word of the mixed-radix 512-point NTT `top_stage` through a fixed phase program.
- Default program: 1 → 3 → 2 → 4 → 5.
- Advances one phase per completion event on `done_flag`, instead of using fixed testbench delays.
- Sits between the system/host control and `top_stage`; provides per-phase timeout detection and abort.

---
 rtl/ntt_conf_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ntt_conf_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_conf_sequencer.sv
// Phase sequencer for the mixed-radix 512-point NTT top_stage.
// Steps the conf word through a fixed program, one phase per done_flag rising edge.
module ntt_conf_sequencer #(
   parameter int         NUM_PH  = 5,
   parameter logic [3:0] CONF_P0 = 4'd1,
   parameter logic [3:0] CONF_P1 = 4'd3,
   parameter logic [3:0] CONF_P2 = 4'd2,
   parameter logic [3:0] CONF_P3 = 4'd4,
   parameter logic [3:0] CONF_P4 = 4'd5,
   parameter logic [3:0] CONF_P5 = 4'd0,
   parameter logic [3:0] CONF_P6 = 4'd0,
   parameter logic [3:0] CONF_P7 = 4'd0,
   parameter int         MIN_CYC = 2,
   parameter int         TIMEOUT = 8192
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] done_flag,
   output logic [3:0] conf,
   output logic       busy,
   output logic [2:0] phase,
   output logic       seq_done,
   output logic       timeout_err,
   output logic [2:0] err_phase
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_CYC);
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0]       LAST_PH = 3'(NUM_PH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN,
      S_ERR
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic [3:0]       conf_q, conf_d;
   logic             busy_q, busy_d;
   logic             seq_done_q, seq_done_d;
   logic             timeout_err_q, timeout_err_d;
   logic [2:0]       err_phase_q, err_phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       done_q, done_d;
   logic             ev;

   function automatic logic [3:0] conf_for(input logic [2:0] idx);
      case (idx)
         3'd0: conf_for = CONF_P0;
         3'd1: conf_for = CONF_P1;
         3'd2: conf_for = CONF_P2;
         3'd3: conf_for = CONF_P3;
         3'd4: conf_for = CONF_P4;
         3'd5: conf_for = CONF_P5;
         3'd6: conf_for = CONF_P6;
         3'd7: conf_for = CONF_P7;
      endcase
   endfunction

   always_comb begin
      // Edge-qualified completion: a flag already high on phase entry never counts.
      ev            = (|(done_flag & ~done_q)) && (cnt_q >= CNT_MIN);
      state_d       = state_q;
      phase_d       = phase_q;
      conf_d        = conf_q;
      busy_d        = busy_q;
      seq_done_d    = 1'b0;
      timeout_err_d = timeout_err_q;
      err_phase_d   = err_phase_q;
      cnt_d         = cnt_q;
      done_d        = done_flag;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               phase_d = 3'd0;
               conf_d  = conf_for(3'd0);
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               phase_d = 3'd0;
               conf_d  = 4'd0;
               busy_d  = 1'b0;
            end else if (ev && (phase_q < LAST_PH)) begin
               phase_d = phase_q + 3'd1;
               conf_d  = conf_for(phase_q + 3'd1);
               cnt_d   = '0;
            end else if (ev) begin
               state_d    = S_FIN;
               phase_d    = 3'd0;
               conf_d     = 4'd0;
               busy_d     = 1'b0;
               seq_done_d = 1'b1;
            end else if (cnt_q == CNT_TO) begin
               state_d       = S_ERR;
               phase_d       = 3'd0;
               conf_d        = 4'd0;
               busy_d        = 1'b0;
               timeout_err_d = 1'b1;
               err_phase_d   = phase_q;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            if (start) begin
               state_d       = S_RUN;
               phase_d       = 3'd0;
               conf_d        = conf_for(3'd0);
               busy_d        = 1'b1;
               cnt_d         = '0;
               timeout_err_d = 1'b0;
               err_phase_d   = 3'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         phase_q       <= 3'd0;
         conf_q        <= 4'd0;
         busy_q        <= 1'b0;
         seq_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         err_phase_q   <= 3'd0;
         cnt_q         <= '0;
         done_q        <= 2'b00;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         conf_q        <= conf_d;
         busy_q        <= busy_d;
         seq_done_q    <= seq_done_d;
         timeout_err_q <= timeout_err_d;
         err_phase_q   <= err_phase_d;
         cnt_q         <= cnt_d;
         done_q        <= done_d;
      end
   end

   assign conf        = conf_q;
   assign busy        = busy_q;
   assign phase       = phase_q;
   assign seq_done    = seq_done_q;
   assign timeout_err = timeout_err_q;
   assign err_phase   = err_phase_q;

endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Directed bench for ntt_conf_sequencer: a default-parameter instance plus a
// TIMEOUT=16 instance sharing the same stimulus, checked with immediate assertions.
module tb_ntt_conf_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [1:0] done_flag;

   logic [3:0] conf, conf_t;
   logic       busy, busy_t;
   logic [2:0] phase, phase_t;
   logic       seq_done, seq_done_t;
   logic       timeout_err, timeout_err_t;
   logic [2:0] err_phase, err_phase_t;

   int n_checks = 0;
   int n_fail   = 0;

   ntt_conf_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .done_flag  (done_flag),
      .conf       (conf),
      .busy       (busy),
      .phase      (phase),
      .seq_done   (seq_done),
      .timeout_err(timeout_err),
      .err_phase  (err_phase)
   );

   ntt_conf_sequencer #(.TIMEOUT(16)) dut_to (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .done_flag  (done_flag),
      .conf       (conf_t),
      .busy       (busy_t),
      .phase      (phase_t),
      .seq_done   (seq_done_t),
      .timeout_err(timeout_err_t),
      .err_phase  (err_phase_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic [1:0] d);
      start     = s;
      abort     = a;
      done_flag = d;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   logic [3:0] prog [5];

   initial begin
      prog[0] = 4'd1; prog[1] = 4'd3; prog[2] = 4'd2; prog[3] = 4'd4; prog[4] = 4'd5;

      // Reset state
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'b00);
      #2;
      checkOutput("rst_conf", 16'(conf), 16'd0);
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_phase", 16'(phase), 16'd0);
      checkOutput("rst_seq_done", 16'(seq_done), 16'd0);
      checkOutput("rst_terr", 16'(timeout_err), 16'd0);
      checkOutput("rst_err_phase", 16'(err_phase), 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      waitCycles(2);
      checkOutput("idle_conf", 16'(conf), 16'd0);

      // Full program, edge 20 cycles into each phase
      $display("[TB] full program");
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("full_start_conf", 16'(conf), 16'd1);
      checkOutput("full_start_busy", 16'(busy), 16'd1);
      checkOutput("full_start_phase", 16'(phase), 16'd0);
      for (int i = 0; i < 5; i++) begin
         waitCycles(20);
         applyStimulus(1'b0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput($sformatf("full_pre_conf%0d", i), 16'(conf), 16'(prog[i]));
         waitCycles(1);
         if (i < 4) begin
            checkOutput($sformatf("full_conf%0d", i + 1), 16'(conf), 16'(prog[i + 1]));
            checkOutput($sformatf("full_phase%0d", i + 1), 16'(phase), 16'(i + 1));
         end else begin
            checkOutput("full_fin_seq_done", 16'(seq_done), 16'd1);
            checkOutput("full_fin_conf", 16'(conf), 16'd0);
            checkOutput("full_fin_busy", 16'(busy), 16'd0);
            checkOutput("full_fin_phase", 16'(phase), 16'd0);
         end
         applyStimulus(1'b0, 1'b0, 2'b00);
      end
      waitCycles(1);
      checkOutput("full_post_seq_done", 16'(seq_done), 16'd0);
      checkOutput("full_post_busy", 16'(busy), 16'd0);
      checkOutput("full_post_conf", 16'(conf), 16'd0);

      // Stale flag held high from before start
      $display("[TB] stale flag");
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0, 2'b01);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(3);
      checkOutput("stale_hold_conf", 16'(conf), 16'd1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      waitCycles(2);
      checkOutput("stale_pre_conf", 16'(conf), 16'd1);
      checkOutput("stale_pre_phase", 16'(phase), 16'd0);
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(1);
      checkOutput("stale_adv_conf", 16'(conf), 16'd3);
      checkOutput("stale_adv_phase", 16'(phase), 16'd1);
      applyStimulus(1'b0, 1'b1, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("stale_abort_conf", 16'(conf), 16'd0);
      waitCycles(1);

      // Early edge at cnt=0 ignored, edge at cnt=3 accepted
      $display("[TB] early edge");
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b10);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("early_conf", 16'(conf), 16'd1);
      checkOutput("early_phase", 16'(phase), 16'd0);
      waitCycles(2);
      applyStimulus(1'b0, 1'b0, 2'b10);
      checkOutput("early_pre_conf", 16'(conf), 16'd1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("early_adv_conf", 16'(conf), 16'd3);
      checkOutput("early_adv_phase", 16'(phase), 16'd1);

      // Start while busy ignored, then abort in phase 3
      $display("[TB] abort and start-while-busy");
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("busy_start_phase", 16'(phase), 16'd1);
      checkOutput("busy_start_conf", 16'(conf), 16'd3);
      checkOutput("busy_start_busy", 16'(busy), 16'd1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("abort_ph2_conf", 16'(conf), 16'd2);
      waitCycles(2);
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("abort_ph3_conf", 16'(conf), 16'd4);
      checkOutput("abort_ph3_phase", 16'(phase), 16'd3);
      applyStimulus(1'b0, 1'b1, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("abort_conf", 16'(conf), 16'd0);
      checkOutput("abort_busy", 16'(busy), 16'd0);
      checkOutput("abort_seq_done", 16'(seq_done), 16'd0);
      checkOutput("abort_phase", 16'(phase), 16'd0);
      waitCycles(3);
      checkOutput("abort_idle_busy", 16'(busy), 16'd0);

      // Async reset mid-run during phase 2
      $display("[TB] async reset");
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      for (int p = 0; p < 2; p++) begin
         waitCycles(2);
         applyStimulus(1'b0, 1'b0, 2'b01);
         waitCycles(1);
         applyStimulus(1'b0, 1'b0, 2'b00);
      end
      checkOutput("arst_pre_conf", 16'(conf), 16'd2);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("arst_conf", 16'(conf), 16'd0);
      checkOutput("arst_busy", 16'(busy), 16'd0);
      checkOutput("arst_phase", 16'(phase), 16'd0);
      #2;
      rst = 1'b1;
      waitCycles(3);
      checkOutput("arst_idle_busy", 16'(busy), 16'd0);
      checkOutput("arst_idle_conf", 16'(conf), 16'd0);

      // Timeout on the TIMEOUT=16 instance, no flag in phase 2
      $display("[TB] timeout");
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      for (int p = 0; p < 2; p++) begin
         waitCycles(2);
         applyStimulus(1'b0, 1'b0, 2'b10);
         waitCycles(1);
         applyStimulus(1'b0, 1'b0, 2'b00);
      end
      checkOutput("to_entry_phase", 16'(phase_t), 16'd2);
      waitCycles(15);
      checkOutput("to_pre_terr", 16'(timeout_err_t), 16'd0);
      checkOutput("to_pre_busy", 16'(busy_t), 16'd1);
      waitCycles(1);
      checkOutput("to_terr", 16'(timeout_err_t), 16'd1);
      checkOutput("to_err_phase", 16'(err_phase_t), 16'd2);
      checkOutput("to_conf", 16'(conf_t), 16'd0);
      checkOutput("to_busy", 16'(busy_t), 16'd0);
      applyStimulus(1'b0, 1'b1, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("to_abort_terr", 16'(timeout_err_t), 16'd1);
      applyStimulus(1'b1, 1'b0, 2'b00);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("to_restart_conf", 16'(conf_t), 16'd1);
      checkOutput("to_restart_terr", 16'(timeout_err_t), 16'd0);
      checkOutput("to_restart_err_phase", 16'(err_phase_t), 16'd0);

      // Event on the last allowed cycle beats the timeout
      waitCycles(15);
      applyStimulus(1'b0, 1'b0, 2'b01);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 2'b00);
      checkOutput("to_race_conf", 16'(conf_t), 16'd3);
      checkOutput("to_race_terr", 16'(timeout_err_t), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
